// File: rtl/sdram_pkg.sv
// SDRAM command executor shared definitions.
// Command codes are {cs_n,ras_n,cas_n,we_n}.
package sdram_pkg;

  localparam int CNT_W = 15;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [3:0] CMD_LMR       = 4'b0000;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_NOP       = 4'b0111;

  localparam logic [11:0] A_ALL_BANKS = 12'h400;

  typedef enum logic [2:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // Zero-cycle timings would wrap the down-counter, so they become 1.
  function automatic cnt_t clamp(input int v);
    if (v < 1) return cnt_t'(1);
    return cnt_t'(v);
  endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter that parks at 1.
// expire_o flags the last cycle of a timing window.
module sdram_delay_cnt
  import sdram_pkg::*;
#(
  parameter cnt_t RST_VAL = cnt_t'(1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  cnt_t value_i,
  output logic expire_o
);

  cnt_t cnt_q;

  // Load overrides counting; the count never goes below 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q > cnt_t'(1)) begin
      cnt_q <= cnt_q - cnt_t'(1);
    end
  end

  assign expire_o = (cnt_q == cnt_t'(1));

endmodule

// File: rtl/sdram_cmd_exec.sv
// SDRAM command executor: power-up init, then one command per strobe.
// Optional internal refresh under macro SDRAM_AUTO_REFRESH_EN.
module sdram_cmd_exec
  import sdram_pkg::*;
#(
`ifdef SDRAM_AUTO_REFRESH_EN
  parameter int          T_REFI   = 780,
`endif
  parameter int          T_INIT   = 20000,
  parameter int          T_RP     = 2,
  parameter int          T_RFC    = 7,
  parameter int          T_MRD    = 2,
  parameter int          T_RCD    = 2,
  parameter int          CAS_LAT  = 2,
  parameter int          T_WR     = 2,
  parameter logic [11:0] MODE_REG = 12'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd,
  input  logic        switch,
  input  logic [1:0]  cmd_sent,
  output logic        init_comp,
  output logic        cmd_ready,
  output logic        cmd_done,
  output logic [1:0]  done_tag,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [11:0] sdram_a
);

  state_t      state_q, state_d;
  logic [3:0]  cmd_q;
  logic [3:0]  pins_q;
  logic [11:0] a_q;
  logic        init_q;
  logic [1:0]  tag_q;
  logic        int_q;
  logic        pending;
  logic [3:0]  issue_cmd;
  logic        cnt_load;
  cnt_t        cnt_val;
  logic        cnt_exp;

  function automatic cnt_t delay_of(input logic [3:0] c);
    case (c)
      CMD_ACTIVE:    return clamp(T_RCD);
      CMD_READ:      return clamp(CAS_LAT);
      CMD_WRITE:     return clamp(T_WR);
      CMD_PRECHARGE: return clamp(T_RP);
      CMD_REFRESH:   return clamp(T_RFC);
      CMD_LMR:       return clamp(T_MRD);
      default:       return cnt_t'(1);
    endcase
  endfunction

  sdram_delay_cnt #(
    .RST_VAL(clamp(T_INIT))
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cnt_load),
    .value_i  (cnt_val),
    .expire_o (cnt_exp)
  );

`ifdef SDRAM_AUTO_REFRESH_EN
  cnt_t refi_q;
  logic flag_q;
  logic refi_exp;

  assign refi_exp = init_q && (refi_q == cnt_t'(1));
  assign pending  = flag_q | refi_exp;

  // Refresh interval timer; a pending flag holds expiries until IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refi_q <= clamp(T_REFI);
      flag_q <= 1'b0;
    end else begin
      if (!init_q || refi_exp) refi_q <= clamp(T_REFI);
      else                     refi_q <= refi_q - cnt_t'(1);
      if (state_q == ST_IDLE && pending) flag_q <= 1'b0;
      else if (refi_exp)                 flag_q <= 1'b1;
    end
  end
`else
  assign pending = 1'b0;
`endif

  assign issue_cmd = pending ? CMD_REFRESH : cmd;

  // Next state and counter reload; init steps cover issue cycle plus gap.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = cnt_t'(1);
    unique case (state_q)
      ST_INIT_WAIT: if (cnt_exp) begin
        state_d  = ST_INIT_PRE;
        cnt_load = 1'b1;
        cnt_val  = clamp(T_RP) + cnt_t'(1);
      end
      ST_INIT_PRE: if (cnt_exp) begin
        state_d  = ST_INIT_REF1;
        cnt_load = 1'b1;
        cnt_val  = clamp(T_RFC) + cnt_t'(1);
      end
      ST_INIT_REF1: if (cnt_exp) begin
        state_d  = ST_INIT_REF2;
        cnt_load = 1'b1;
        cnt_val  = clamp(T_RFC) + cnt_t'(1);
      end
      ST_INIT_REF2: if (cnt_exp) begin
        state_d  = ST_INIT_MRS;
        cnt_load = 1'b1;
        cnt_val  = clamp(T_MRD) + cnt_t'(1);
      end
      ST_INIT_MRS: if (cnt_exp) state_d = ST_IDLE;
      ST_IDLE: if (pending || switch) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d  = ST_WAIT;
        cnt_load = 1'b1;
        cnt_val  = delay_of(cmd_q);
      end
      ST_WAIT: if (cnt_exp) state_d = ST_IDLE;
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  // State plus registered pins: a command shows for one cycle on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT_WAIT;
      pins_q  <= CMD_NOP;
      a_q     <= '0;
      init_q  <= 1'b0;
      tag_q   <= '0;
      cmd_q   <= CMD_NOP;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pins_q  <= CMD_NOP;
      a_q     <= '0;
      if (state_d != state_q) begin
        unique case (state_d)
          ST_INIT_PRE: begin
            pins_q <= CMD_PRECHARGE;
            a_q    <= A_ALL_BANKS;
          end
          ST_INIT_REF1, ST_INIT_REF2: pins_q <= CMD_REFRESH;
          ST_INIT_MRS: begin
            pins_q <= CMD_LMR;
            a_q    <= MODE_REG;
          end
          ST_ISSUE: begin
            pins_q <= issue_cmd;
            a_q    <= (issue_cmd == CMD_LMR) ? MODE_REG : '0;
          end
          default: ;
        endcase
      end
      if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
        cmd_q <= issue_cmd;
        int_q <= pending;
        if (!pending) tag_q <= cmd_sent;
      end
      if (state_q == ST_INIT_MRS && state_d == ST_IDLE) init_q <= 1'b1;
    end
  end

  assign init_comp = init_q;
  assign cmd_ready = (state_q == ST_IDLE) && !pending;
  assign cmd_done  = (state_q == ST_WAIT) && cnt_exp && !int_q;
  assign done_tag  = tag_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pins_q;
  assign sdram_a   = a_q;

endmodule

// File: tb/tb_sdram_cmd_exec.sv
// Bench for sdram_cmd_exec: init schedule, commands, strobes in WAIT, reset.
// With SDRAM_AUTO_REFRESH_EN it checks the internal refresh cadence instead.
module tb_sdram_cmd_exec;

  localparam int T_INIT  = 20000;
  localparam int T_RP    = 2;
  localparam int T_RFC   = 7;
  localparam int T_MRD   = 2;
  localparam int T_RCD   = 2;
  localparam int CAS_LAT = 2;
  localparam int T_WR    = 2;
  localparam int T_REFI  = 50;
  localparam logic [11:0] MODE_REG = 12'h020;
  localparam logic [3:0] NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cmd = 4'b0111;
  logic        switch = 1'b0;
  logic [1:0]  cmd_sent = 2'd0;
  logic        init_comp, cmd_ready, cmd_done;
  logic [1:0]  done_tag;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [11:0] sdram_a;
  logic [3:0]  pins;

  int total = 0;
  int bad = 0;

  assign pins = {cs_n, ras_n, cas_n, we_n};

  always #5 clk = ~clk;

`ifdef SDRAM_AUTO_REFRESH_EN
  sdram_cmd_exec #(.T_REFI(T_REFI)) dut (
`else
  sdram_cmd_exec dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .switch      (switch),
    .cmd_sent    (cmd_sent),
    .init_comp   (init_comp),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .done_tag    (done_tag),
    .sdram_cs_n  (cs_n),
    .sdram_ras_n (ras_n),
    .sdram_cas_n (cas_n),
    .sdram_we_n  (we_n),
    .sdram_a     (sdram_a)
  );

  function automatic int model_delay(input logic [3:0] c);
    if (c[3]) return 1;
    case (c[2:0])
      3'b011:  return T_RCD;
      3'b101:  return CAS_LAT;
      3'b100:  return T_WR;
      3'b010:  return T_RP;
      3'b001:  return T_RFC;
      3'b000:  return T_MRD;
      default: return 1;
    endcase
  endfunction

  task automatic check_reset_vals(input string nm);
    total++;
    if ({pins, sdram_a, init_comp, cmd_ready, cmd_done, done_tag} !==
        {NOP, 12'h000, 3'b000, 2'b00}) begin
      bad++;
      $display("FAIL %s: got pins=%b a=%h ic=%b rdy=%b done=%b tag=%0d want NOP/0",
               nm, pins, sdram_a, init_comp, cmd_ready, cmd_done, done_tag);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    switch = 1'b0;
    #1;
    check_reset_vals("reset_assert");
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("reset_hold");
    rst = 1'b1;
  endtask

  task automatic test_init();
    int pre, r1, r2, mrs, idle;
    logic [3:0]  ep;
    logic [11:0] ea;
    logic        ei;
    pre  = T_INIT;
    r1   = pre + T_RP + 1;
    r2   = r1 + T_RFC + 1;
    mrs  = r2 + T_RFC + 1;
    idle = mrs + T_MRD + 1;
    for (int c = 0; c <= idle; c++) begin
      @(negedge clk);
      ep = NOP;
      ea = 12'h000;
      if (c == pre) begin
        ep = 4'b0010;
        ea = 12'h400;
      end else if (c == r1 || c == r2) begin
        ep = 4'b0001;
      end else if (c == mrs) begin
        ep = 4'b0000;
        ea = MODE_REG;
      end
      ei = (c == idle);
      total++;
      if ({pins, sdram_a, init_comp, cmd_ready, cmd_done} !==
          {ep, ea, ei, ei, 1'b0}) begin
        bad++;
        $display("FAIL init c=%0d: got pins=%b a=%h ic=%b rdy=%b done=%b want pins=%b a=%h ic=%b rdy=%b done=0",
                 c, pins, sdram_a, init_comp, cmd_ready, cmd_done, ep, ea, ei, ei);
      end
    end
  endtask

  task automatic run_cmd(input logic [3:0] c, input logic [1:0] tag,
                         input bit noise);
    int d;
    logic [3:0]  ep;
    logic [11:0] ea;
    d = model_delay(c);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin
      bad++;
      $display("FAIL idle: got rdy=%b done=%b want rdy=1 done=0",
               cmd_ready, cmd_done);
    end
    cmd = c;
    cmd_sent = tag;
    switch = 1'b1;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      ep = (k == 1) ? c : NOP;
      ea = (k == 1 && c == 4'b0000) ? MODE_REG : 12'h000;
      total++;
      if ({pins, sdram_a, cmd_ready, cmd_done} !==
          {ep, ea, 1'b0, (k == d + 1)}) begin
        bad++;
        $display("FAIL cmd %b k=%0d: got pins=%b a=%h rdy=%b done=%b want pins=%b a=%h rdy=0 done=%b",
                 c, k, pins, sdram_a, cmd_ready, cmd_done, ep, ea, (k == d + 1));
      end
      if (k == d + 1) begin
        total++;
        if (done_tag !== tag) begin
          bad++;
          $display("FAIL tag cmd %b: got %0d want %0d", c, done_tag, tag);
        end
      end
      if (noise && k <= d) begin
        switch = 1'($urandom_range(0, 1));
        cmd = 4'($urandom);
        cmd_sent = 2'($urandom);
      end else begin
        switch = 1'b0;
      end
    end
  endtask

  task automatic test_active();
    run_cmd(4'b0011, 2'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd(4'b0101, 2'd1, 1'b0);
    run_cmd(4'b0010, 2'd3, 1'b0);
    run_cmd(4'b0000, 2'd0, 1'b0);
    run_cmd(4'b1010, 2'd1, 1'b0);
  endtask

  task automatic test_switch_in_wait();
    for (int i = 0; i < 8; i++)
      run_cmd(4'($urandom), 2'($urandom), 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_cmd(4'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd = 4'b0001;
    cmd_sent = 2'd1;
    switch = 1'b1;
    @(negedge clk);
    switch = 1'b0;
    repeat (T_RFC) @(negedge clk);
    total++;
    if (cmd_done !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_done: got %b want 1", cmd_done);
    end
    rst = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    test_init();
  endtask

  task automatic test_refresh();
    bit busy;
    logic [3:0] ep;
    for (int rel = 1; rel <= 3 * T_REFI + T_RFC + 2; rel++) begin
      @(negedge clk);
      ep = (rel % T_REFI == 0) ? 4'b0001 : NOP;
      busy = (rel >= T_REFI - 1) && (((rel + 1) % T_REFI) <= T_RFC + 1);
      total++;
      if ({pins, cmd_ready, cmd_done} !== {ep, !busy, 1'b0}) begin
        bad++;
        $display("FAIL refresh rel=%0d: got pins=%b rdy=%b done=%b want pins=%b rdy=%b done=0",
                 rel, pins, cmd_ready, cmd_done, ep, !busy);
      end
      switch = (rel == 2 * T_REFI - 1);
      cmd = 4'b0011;
    end
    switch = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
`ifdef SDRAM_AUTO_REFRESH_EN
    test_refresh();
`else
    test_active();
    test_back_to_back();
    test_switch_in_wait();
    test_random();
    test_reset_mid();
    test_active();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
